// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry pipeline stage register made of a main register and a skid register.
//   Every output comes directly from a flop. As a result, in_ready depends only on
//   the stage's own state and never on out_ready. When the stage holds no valid
//   payload, out_data carries the bubble payload NOP_VAL.
//
// Parameters
//   DATA_W   payload width
//   NOP_VAL  bubble payload presented while out_valid is low
//   CNT_W    width of the backpressure stall counter
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      squash every held entry; this cycle's in_data is dropped
//   in_valid   upstream presents in_data
//   in_ready   stage can accept this cycle (low only when both entries are full)
//   in_data    upstream payload
//   out_valid  main entry is valid
//   out_ready  downstream consumes this cycle
//   out_data   main payload (NOP_VAL when out_valid is low)
//   occ        number of entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid high and out_ready low
module pipe_skid_reg #(
  parameter int                 DATA_W  = 136,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   main_reg, main_next;
  logic [DATA_W-1:0]   skid_reg, skid_next;
  logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
  logic                out_valid_reg, out_valid_next;
  logic                in_ready_reg, in_ready_next;
  logic [1:0]          occ_reg, occ_next;
  logic                do_accept;
  logic                do_release;

  // Handshake and next-state logic. The status flags out_valid, in_ready and occ
  // are computed from state_next here and then registered below. This keeps every
  // output a plain flop output.
  always_comb begin
    state_next     = state_reg;
    main_next      = main_reg;
    skid_next      = skid_reg;
    stall_cnt_next = stall_cnt_reg;
    do_accept      = in_valid & in_ready_reg;
    do_release     = out_valid_reg & out_ready;

    if (flush) begin
      // A release in this cycle has already been taken by downstream.
      // A pending accept is dropped.
      state_next = EMPTY;
      main_next  = NOP_VAL;
      skid_next  = NOP_VAL;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (do_accept) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (do_accept && do_release) begin
            main_next = in_data;
          end else if (do_accept) begin
            state_next = TWO;
            skid_next  = in_data;
          end else if (do_release) begin
            state_next = EMPTY;
            main_next  = NOP_VAL;
          end
        end
        TWO: begin
          // in_ready is low here, so the only possible event is a release.
          if (do_release) begin
            state_next = ONE;
            main_next  = skid_reg;
            skid_next  = NOP_VAL;
          end
        end
        default: begin
          state_next = EMPTY;
          main_next  = NOP_VAL;
          skid_next  = NOP_VAL;
        end
      endcase
    end

    // The stall counter counts observed backpressure. A flush does not clear it.
    if (out_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    out_valid_next = (state_next != EMPTY);
    in_ready_next  = (state_next != TWO);
    occ_next       = (state_next == TWO) ? 2'd2 :
                     (state_next == ONE) ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_reg      <= NOP_VAL;
      skid_reg      <= '0;
      stall_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      occ_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      stall_cnt_reg <= stall_cnt_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
      occ_reg       <= occ_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = main_reg;
  assign in_ready  = in_ready_reg;
  assign occ       = occ_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
